fc_tile_sequencer: RTL and testbench
====================================

# fc_tile_sequencer

Controller that runs the fully-connected MAC array over an input vector wider than one array pass. The vector is split into `NUM_TILES` tiles of `TILE_INPUTS` elements. For each tile it:
- requests the tile's activations and weights from the upstream buffers,
- fires the MAC array,
- waits for the array's finish pulse.

The MAC array sums the tiles internally. This block clears the array at the start of each job, latches the final sums, and returns them on a valid/ready handshake. It sits between the layer scheduler (start/result) and the FC MAC array plus its tile buffers.

## Interface
Parameters:
- `NUM_TILES`, 4, tiles per job (≥1)
- `NUM_OUTPUTS`, 10, output neurons
- `ACC_WIDTH`, 32, accumulator width per output
- `TIMEOUT_CYCLES`, 64, maximum wait for `mac_finish` per tile (used only with `FC_SEQ_TIMEOUT_EN`)
- `IDX_W`, 2, `tile_idx` width, ≥ clog2(`NUM_TILES`)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  job request, sampled in IDLE or ERR
- `busy`  out  1  high in every state except IDLE and ERR
- `tile_req`  out  1  request for tile `tile_idx`; held until acknowledged
- `tile_idx`  out  IDX_W  current tile number
- `tile_ack`  in  1  tile data and weights are stable on the MAC array inputs
- `mac_clr`  out  1  one-cycle active-high clear to the MAC array
- `mac_valid`  out  1  one-cycle launch pulse to the MAC array
- `mac_finish`  in  1  one-cycle completion pulse from the MAC array
- `mac_data_flat`  in  ACC_WIDTH*NUM_OUTPUTS  cumulative sums from the MAC array
- `result_flat`  out  ACC_WIDTH*NUM_OUTPUTS  latched job result
- `result_valid`  out  1  result available
- `result_ready`  in  1  consumer accepts the result
- `error`  out  1  sticky timeout flag
- `perf_cycles`  out  32  cycles used by the last job

## Operation
States and transitions:
- **IDLE**: on `start` → CLEAR. Clear `tile_idx` and `perf_cycles`.
- **CLEAR**: assert `mac_clr` for one cycle → REQ.
- **REQ**: hold `tile_req`=1. When `tile_ack`=1 while `tile_req`=1 → ISSUE. `tile_idx` stays constant throughout REQ.
- **ISSUE**: assert `mac_valid` for one cycle → WAIT. Clear the timeout counter.
- **WAIT**: on `mac_finish`:
  - if `tile_idx`==`NUM_TILES`-1: latch `mac_data_flat` into `result_flat` → OUT;
  - otherwise increment `tile_idx` → REQ.
- **OUT**: hold `result_valid`=1. When `result_ready`=1 → IDLE.
- **ERR**: entered only on timeout. `error`=1. On `start` → CLEAR, with `error` cleared in the same transition.

Counting and data rules:
- `perf_cycles` increments every cycle from CLEAR up to and including the cycle that enters OUT. It saturates at 2^32-1 and holds until the next job starts.
- `result_flat` is copied as-is: no arithmetic and no width change. It changes only when entering OUT.

Boundary conditions:
- `start` while busy: ignored, not queued.
- `mac_finish` outside WAIT: ignored.
- `tile_ack` outside REQ: ignored.
- `result_ready` without `result_valid`: ignored.
- `NUM_TILES`=1: REQ, ISSUE and WAIT each run exactly once.
- Reset mid-job: all state drops to IDLE immediately. The MAC array is not cleared by this block on reset; the next job's CLEAR handles it.

## Timing
Reset values: `busy`, `tile_req`, `tile_idx`, `mac_clr`, `mac_valid`, `result_valid` and `error` are 0; `result_flat` and `perf_cycles` are 0.

All outputs are registered. With `start` seen in cycle 0:
- `mac_clr`=1 in cycle 1.
- `tile_req`=1 from cycle 2.
- `tile_ack` sampled in cycle k gives `mac_valid`=1 in cycle k+1.
- `mac_finish` in cycle m gives either `tile_req`=1 (next tile) or `result_valid`=1 in cycle m+1.

Minimum job length, with `tile_ack` and `mac_finish` arriving immediately: 2 + 3·NUM_TILES cycles to `result_valid`.

## Configuration
`FC_SEQ_TIMEOUT_EN` compiles the timeout in or out:
- **Defined**: WAIT counts cycles. If `mac_finish` has not arrived once the count reaches `TIMEOUT_CYCLES`:
  - go to ERR with `error`=1;
  - `result_valid` is not asserted;
  - `perf_cycles` freezes at its current value.
- **Undefined**: WAIT waits indefinitely, `error` is constant 0, and ERR is unreachable.

## Test plan
- **Basic job**: `NUM_TILES`=4; `tile_ack` and `mac_finish` return 1 cycle after each request/launch; `mac_data_flat` = 0x64 per lane at the final finish → 4 `mac_valid` pulses, `tile_idx` sequence 0,1,2,3, `result_flat` = 0x64 per lane, `perf_cycles` matches the measured count.
- **Back-pressure**: hold `result_ready`=0 for 10 cycles → `result_valid` stays 1 and `result_flat` is stable; `result_ready`=1 → IDLE on the next cycle, `busy`=0.
- **Delayed ack / spurious inputs**: `tile_ack` delayed 5 cycles, and `mac_finish` pulsed during REQ → `tile_req` held for 5 cycles, the spurious finish is ignored, no extra `mac_valid`.
- **Timeout** (macro defined, `TIMEOUT_CYCLES`=64): never send `mac_finish` for tile 2 → `error`=1 after 64 cycles in WAIT, `busy`=0, no `result_valid`; then `start` → `error`=0 and `mac_clr` pulses.
- **Reset mid-job**: assert `rst`=0 during WAIT of tile 1 → all outputs read 0 in the same cycle; after release a new `start` completes normally.
- **`start` while busy**: pulse `start` in WAIT → ignored; exactly one result is produced.

Source files
------------

// File: rtl/fc_tile_sequencer.sv
// Tile sequencer for the FC MAC array: clear, then request/launch/await each tile, then return sums.
// Define FC_SEQ_TIMEOUT_EN to compile in the per-tile mac_finish timeout and the ERR state.
module fc_tile_sequencer #(
  parameter int unsigned NUM_TILES      = 4,
  parameter int unsigned NUM_OUTPUTS    = 10,
  parameter int unsigned ACC_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned IDX_W          = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             tile_req,
  output logic [IDX_W-1:0]                 tile_idx,
  input  logic                             tile_ack,
  output logic                             mac_clr,
  output logic                             mac_valid,
  input  logic                             mac_finish,
  input  logic [ACC_WIDTH*NUM_OUTPUTS-1:0] mac_data_flat,
  output logic [ACC_WIDTH*NUM_OUTPUTS-1:0] result_flat,
  output logic                             result_valid,
  input  logic                             result_ready,
  output logic                             error,
  output logic [31:0]                      perf_cycles
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StClear = 3'd1;
  localparam logic [2:0] StReq   = 3'd2;
  localparam logic [2:0] StIssue = 3'd3;
  localparam logic [2:0] StWait  = 3'd4;
  localparam logic [2:0] StOut   = 3'd5;
  localparam logic [2:0] StErr   = 3'd6;

  localparam logic [IDX_W-1:0] LastTile = IDX_W'(NUM_TILES - 1);

  if (NUM_TILES < 1 || TIMEOUT_CYCLES < 1 || (64'd1 << IDX_W) < 64'(NUM_TILES)) begin : g_bad_cfg
    $error("fc_tile_sequencer: invalid NUM_TILES / TIMEOUT_CYCLES / IDX_W");
  end

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] tile_idx_d;
  logic [31:0]      perf_d;
  logic             timeout;

`ifdef FC_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else if (state_q == StIssue) begin
      tmo_q <= '0;
    end else if (state_q == StWait && !mac_finish) begin
      tmo_q <= tmo_q + TmoW'(1);
    end
  end

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle without a finish pulse.
  assign timeout = (state_q == StWait) && !mac_finish && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    tile_idx_d = tile_idx;
    perf_d     = perf_cycles;
    case (state_q)
      StIdle, StErr: begin
        if (start) begin
          state_d    = StClear;
          tile_idx_d = '0;
          perf_d     = '0;
        end
      end
      StClear: state_d = StReq;
      StReq: begin
        if (tile_ack) state_d = StIssue;
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (mac_finish) begin
          if (tile_idx == LastTile) begin
            state_d = StOut;
          end else begin
            tile_idx_d = tile_idx + IDX_W'(1);
            state_d    = StReq;
          end
        end else if (timeout) begin
          state_d = StErr;
        end
      end
      StOut: begin
        if (result_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Count CLEAR through the cycle that leaves WAIT; saturate rather than wrap.
    if ((state_q == StClear || state_q == StReq || state_q == StIssue || state_q == StWait) &&
        perf_cycles != 32'hFFFF_FFFF) begin
      perf_d = perf_cycles + 32'd1;
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      tile_idx     <= '0;
      perf_cycles  <= '0;
      busy         <= 1'b0;
      tile_req     <= 1'b0;
      mac_clr      <= 1'b0;
      mac_valid    <= 1'b0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      result_flat  <= '0;
    end else begin
      state_q      <= state_d;
      tile_idx     <= tile_idx_d;
      perf_cycles  <= perf_d;
      busy         <= (state_d != StIdle) && (state_d != StErr);
      tile_req     <= (state_d == StReq);
      mac_clr      <= (state_d == StClear);
      mac_valid    <= (state_d == StIssue);
      result_valid <= (state_d == StOut);
      error        <= (state_d == StErr);
      if (state_q == StWait && state_d == StOut) begin
        result_flat <= mac_data_flat;
      end
    end
  end

endmodule

// File: tb/tb_fc_tile_sequencer.sv
// Directed self-checking bench for fc_tile_sequencer (default parameters).
// Timeout scenario runs only when FC_SEQ_TIMEOUT_EN is defined.
module tb_fc_tile_sequencer;

  localparam int NT   = 4;
  localparam int NOUT = 10;
  localparam int ACCW = 32;
  localparam int IW   = 2;
  localparam int W    = ACCW * NOUT;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          tile_req;
  logic [IW-1:0] tile_idx;
  logic          tile_ack = 1'b0;
  logic          mac_clr;
  logic          mac_valid;
  logic          mac_finish = 1'b0;
  logic [W-1:0]  mac_data_flat = '0;
  logic [W-1:0]  result_flat;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic          error;
  logic [31:0]   perf_cycles;

  int n_checks = 0;
  int n_errors = 0;

  // Per-job observations filled in by run_job.
  int job_hung, job_cyc, job_valids, job_tiles, job_req_cycles, job_wait_cnt;
  int job_idx[8];

  fc_tile_sequencer #(
    .NUM_TILES     (NT),
    .NUM_OUTPUTS   (NOUT),
    .ACC_WIDTH     (ACCW),
    .TIMEOUT_CYCLES(64),
    .IDX_W         (IW)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .tile_req     (tile_req),
    .tile_idx     (tile_idx),
    .tile_ack     (tile_ack),
    .mac_clr      (mac_clr),
    .mac_valid    (mac_valid),
    .mac_finish   (mac_finish),
    .mac_data_flat(mac_data_flat),
    .result_flat  (result_flat),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .error        (error),
    .perf_cycles  (perf_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] lanes(input logic [31:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NOUT; i++) r[i*ACCW +: ACCW] = v;
    return r;
  endfunction

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_tile_req"}, tile_req, 0);
    check({pfx, "_tile_idx"}, tile_idx, 0);
    check({pfx, "_clr_valid"}, {mac_clr, mac_valid}, 0);
    check({pfx, "_result_valid"}, result_valid, 0);
    check({pfx, "_error"}, error, 0);
    check({pfx, "_result_flat"}, result_flat, 0);
    check({pfx, "_perf"}, perf_cycles, 0);
  endtask

  // Drives one job: ack after ack_dly extra REQ cycles, finish after fin_dly extra WAIT cycles.
  // Stops on result_valid, error, an in-WAIT reset (rst_tile) or the cycle budget.
  task automatic run_job(input int ack_dly, input int fin_dly, input logic [W-1:0] data,
                         input bit spurious, input bit start_in_wait, input int rst_tile,
                         input int stall_tile);
    int  req_cnt, wait_cnt, cyc, cur;
    bit  in_wait, done;
    req_cnt = 0; wait_cnt = 0; in_wait = 0; done = 0;
    job_hung = 0; job_valids = 0; job_tiles = 0; job_req_cycles = 0; job_wait_cnt = 0;
    for (int i = 0; i < 8; i++) job_idx[i] = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    check("clr_pulse", mac_clr, 1);
    check("busy_in_clear", busy, 1);
    while (!done) begin
      tile_ack = 1'b0;
      mac_finish = 1'b0;
      start = 1'b0;
      if (result_valid || error || cyc >= 1000) begin
        done = 1;
        job_hung = (cyc >= 1000);
      end else begin
        if (tile_req) begin
          if (req_cnt == 0) begin
            job_idx[job_tiles % 8] = int'(tile_idx);
            job_tiles++;
            if (spurious) mac_finish = 1'b1;
          end
          if (req_cnt == ack_dly) tile_ack = 1'b1;
          req_cnt++;
          job_req_cycles++;
        end else begin
          req_cnt = 0;
        end
        if (mac_valid) begin
          job_valids++;
          in_wait = 1;
          wait_cnt = 0;
        end else if (in_wait) begin
          cur = job_tiles - 1;
          if (rst_tile == cur) begin
            rst = 1'b0;
            #1;
            check_all_zero("midjob_rst");
            #1;
            rst = 1'b1;
            done = 1;
          end else begin
            if (start_in_wait && cur == 1 && wait_cnt == 0) start = 1'b1;
            if (cur != stall_tile && wait_cnt == fin_dly) begin
              mac_finish = 1'b1;
              in_wait = 0;
              mac_data_flat = (cur == NT - 1) ? data : lanes(32'hBAD0_0000 + 32'(cur));
            end
            wait_cnt++;
            job_wait_cnt = wait_cnt;
          end
        end
        if (!done) begin
          step();
          cyc++;
        end
      end
    end
    job_cyc = cyc;
    tile_ack = 1'b0;
    mac_finish = 1'b0;
    start = 1'b0;
  endtask

  task automatic release_result();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("idle_after_ready_rv", result_valid, 0);
    check("idle_after_ready_busy", busy, 0);
  endtask

  initial begin
    int hits;
    // Reset
    step();
    step();
    check_all_zero("reset");
    rst = 1'b1;
    step();
    check_all_zero("post_reset");

    // Stray handshakes while idle do nothing.
    tile_ack = 1'b1; mac_finish = 1'b1; result_ready = 1'b1;
    hits = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      hits += int'(busy) + int'(tile_req) + int'(mac_valid) + int'(result_valid) + int'(mac_clr);
    end
    tile_ack = 1'b0; mac_finish = 1'b0; result_ready = 1'b0;
    check("idle_stray_inputs", hits, 0);

    // Basic job: each response one cycle late -> 5 cycles per tile.
    run_job(1, 1, lanes(32'h64), 0, 0, -1, -1);
    check("basic_no_hang", job_hung, 0);
    check("basic_latency", job_cyc, 2 + NT * 5);
    check("basic_mac_valids", job_valids, NT);
    for (int i = 0; i < NT; i++) check($sformatf("basic_idx%0d", i), job_idx[i], i);
    check("basic_result", result_flat, lanes(32'h64));
    check("basic_perf", perf_cycles, 1 + NT * 5);

    // Back-pressure: result held while the array keeps changing its outputs.
    mac_data_flat = lanes(32'hDEAD_BEEF);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!result_valid || result_flat !== lanes(32'h64)) hits++;
    end
    check("bp_held", hits, 0);
    check("bp_busy", busy, 1);
    release_result();
    check("idle_result_holds", result_flat, lanes(32'h64));
    check("idle_perf_holds", perf_cycles, 1 + NT * 5);

    // Delayed ack (6 REQ cycles per tile) with a stray finish during REQ.
    run_job(5, 0, lanes(32'h1234_5678), 1, 0, -1, -1);
    check("dly_no_hang", job_hung, 0);
    check("dly_latency", job_cyc, 2 + NT * 8);
    check("dly_req_cycles", job_req_cycles, NT * 6);
    check("dly_mac_valids", job_valids, NT);
    check("dly_result", result_flat, lanes(32'h1234_5678));
    check("dly_perf", perf_cycles, 1 + NT * 8);
    release_result();

    // start pulsed mid-job is dropped: one result, then idle.
    run_job(0, 0, lanes(32'hA5A5_A5A5), 0, 1, -1, -1);
    check("busy_start_latency", job_cyc, 2 + NT * 3);
    check("busy_start_result", result_flat, lanes(32'hA5A5_A5A5));
    check("busy_start_perf", perf_cycles, 1 + NT * 3);
    release_result();
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      hits += int'(busy) + int'(mac_clr);
    end
    check("busy_start_no_second_job", hits, 0);

    // Reset during WAIT of tile 1, then a clean job.
    run_job(0, 2, lanes(32'h0000_0011), 0, 0, 1, -1);
    check("rst_reached_tile1", job_tiles, 2);
    step();
    check("rst_idle_busy", busy, 0);
    run_job(0, 0, lanes(32'h0000_0077), 0, 0, -1, -1);
    check("after_rst_latency", job_cyc, 2 + NT * 3);
    check("after_rst_result", result_flat, lanes(32'h0000_0077));
    release_result();

`ifdef FC_SEQ_TIMEOUT_EN
    // Tile 2 never finishes: ERR after 64 WAIT cycles.
    run_job(0, 0, lanes(32'h1), 0, 0, -1, 2);
    check("tmo_no_hang", job_hung, 0);
    check("tmo_error", error, 1);
    check("tmo_busy", busy, 0);
    check("tmo_no_result", result_valid, 0);
    check("tmo_wait_cycles", job_wait_cnt, 64);
    check("tmo_mac_valids", job_valids, 3);
    start = 1'b1;
    step();
    start = 1'b0;
    check("tmo_restart_error", error, 0);
    check("tmo_restart_clr", mac_clr, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
